// File: rtl/int_return_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_return_unit_pkg
//  Description : Shared definitions for the interrupt return unit: FSM
//                state encoding, default widths, well-known interrupt
//                vectors/priorities and a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_return_unit_pkg;

    // Default widths
    localparam int DEF_AW = 32;     // PC / vector width
    localparam int DEF_PW = 2;      // priority width, 0 = masked

    // FSM state encoding
    localparam int ST_W = 2;
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ENTER  = 2'd1;
    localparam state_t ST_RETURN = 2'd2;

    // Handler entry points shared with the interrupt controller
    localparam logic [DEF_AW-1:0] VEC_SYSCALL = 32'h0000_0040;
    localparam logic [DEF_AW-1:0] VEC_BUTTON  = 32'h0000_0080;

    // Source priorities
    localparam logic [DEF_PW-1:0] PRI_SYSCALL = 2'd1;
    localparam logic [DEF_PW-1:0] PRI_BUTTON  = 2'd2;

    // Width of a counter able to hold 0..d inclusive (d a power of two)
    function automatic int depth_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage : int_return_unit_pkg
`default_nettype wire

// File: rtl/int_return_unit_epc.sv
`default_nettype none
// ============================================================================
//  Module      : epc_stack
//  Description : DEPTH x DW LIFO holding {resume PC, priority} entries of
//                nested interrupts. Registered storage, combinational top.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_push/i_din  - write i_din as new top (ignored when full)
//                i_pop         - discard top entry (ignored when empty)
//                o_top         - current top entry (undefined when empty)
//                o_count       - number of stored entries, 0..DEPTH
//                o_full/o_empty- occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module epc_stack #(
    parameter int DEPTH = 4,
    parameter int DW    = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_din,
    output logic [DW-1:0]            o_top,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                c_IW      = $clog2(DEPTH);
    localparam logic [c_IW-1:0]   c_IDX_ONE = 1;
    localparam logic [c_IW:0]     c_CNT_ONE = 1;
    localparam logic [c_IW:0]     c_FULL    = (c_IW+1)'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_IW:0]   r_count;
    logic [c_IW-1:0] w_wr_idx;
    logic [c_IW-1:0] w_top_idx;
    logic            w_do_push;
    logic            w_do_pop;

    // The low bits of the count address the next free slot; one below is
    // the top. At count==DEPTH the low bits wrap to 0, so top = DEPTH-1.
    assign w_wr_idx  = r_count[c_IW-1:0];
    assign w_top_idx = w_wr_idx - c_IDX_ONE;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_top     = r_mem[w_top_idx];

    // Pop takes precedence if both are ever requested together; the
    // controlling FSM never does that.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !o_full && !w_do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (w_do_pop) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    // Contents need no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule : epc_stack
`default_nettype wire

// File: rtl/int_return_unit.sv
`default_nettype none
// ============================================================================
//  Module      : int_return_unit
//  Description : Interrupt responder. Accepts a pending interrupt, saves the
//                resume PC on a nested EPC stack and redirects the pipeline to
//                the handler vector; on RTI pops the stack and redirects back.
//  Ports       : clk, rst             - clock, asynchronous active-high reset
//                i_ie                 - global interrupt enable
//                i_int_req/vec/pri    - pending request from the controller
//                i_resume_pc          - address to resume at after handler
//                i_rti                - RTI decoded in the IR stage (pulse)
//                o_int_ack            - request accepted (pulse)
//                o_flush              - bubble IR/ALU stages (pulse)
//                o_redirect_valid/pc  - PC redirect (pulse + target)
//                o_cur_pri            - priority of active handler, 0 if none
//                o_depth              - current nesting level
//                o_rti_err            - RTI with empty stack (pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module int_return_unit
    import int_return_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEF_AW,
    parameter int PW    = DEF_PW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_ie,
    input  logic                        i_int_req,
    input  logic [AW-1:0]               i_int_vec,
    input  logic [PW-1:0]               i_int_pri,
    input  logic [AW-1:0]               i_resume_pc,
    input  logic                        i_rti,
    output logic                        o_int_ack,
    output logic                        o_flush,
    output logic                        o_redirect_valid,
    output logic [AW-1:0]               o_redirect_pc,
    output logic [PW-1:0]               o_cur_pri,
    output logic [depth_w(DEPTH)-1:0]   o_depth,
    output logic                        o_rti_err
);

    localparam int c_DW = AW + PW;
    localparam int c_CW = depth_w(DEPTH);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next_state;
    logic [AW-1:0]     r_target;

    logic [c_DW-1:0]   w_stk_top;
    logic [c_CW-1:0]   w_stk_count;
    logic              w_stk_full;
    logic              w_stk_empty;

    logic              w_idle;
    logic              w_accept;
    logic              w_rti_ok;
    logic              w_rti_err;
    logic [PW-1:0]     w_cur_pri;
    logic [AW-1:0]     w_top_epc;

    // ------------------------------------------------------------------
    // EPC stack: each entry is {resume_pc, priority}
    // ------------------------------------------------------------------
    epc_stack #(
        .DEPTH   (DEPTH),
        .DW      (c_DW)
    ) u_epc_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_rti_ok),
        .i_din   ({i_resume_pc, i_int_pri}),
        .o_top   (w_stk_top),
        .o_count (w_stk_count),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    // The active priority is simply the priority stored with the top
    // entry, so push and pop update it in the same edge as the depth.
    assign w_cur_pri = w_stk_empty ? '0 : w_stk_top[PW-1:0];
    assign w_top_epc = w_stk_top[c_DW-1:PW];

    // ------------------------------------------------------------------
    // Decision logic (only IDLE may accept or return)
    // ------------------------------------------------------------------
    // Gating with rst keeps the combinational pulses quiet during reset.
    assign w_idle    = (r_state == ST_IDLE) && !rst;

    assign w_rti_ok  = w_idle && i_rti && !w_stk_empty;
    assign w_rti_err = w_idle && i_rti &&  w_stk_empty;

    // RTI has priority over a simultaneous request; the request is held by
    // the controller and re-evaluated once the return has completed.
    assign w_accept  = w_idle && i_int_req && i_ie && !i_rti &&
                       (i_int_pri > w_cur_pri) && !w_stk_full;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_rti_ok) begin
                    w_next_state = ST_RETURN;
                end else if (w_accept) begin
                    w_next_state = ST_ENTER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ENTER:  w_next_state = ST_IDLE;
            ST_RETURN: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        case (r_state)
            ST_ENTER, ST_RETURN: begin
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = r_target;
            end
            default: begin
                o_flush          = 1'b0;
                o_redirect_valid = 1'b0;
                o_redirect_pc    = '0;
            end
        endcase
    end

    // Redirect target: vector on accept, saved EPC on return. Sampling
    // happens only in the decision cycle, so later input changes are moot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= '0;
        end else if (w_rti_ok) begin
            r_target <= w_top_epc;
        end else if (w_accept) begin
            r_target <= i_int_vec;
        end
    end

    assign o_int_ack = w_accept;
    assign o_rti_err = w_rti_err;
    assign o_cur_pri = w_cur_pri;
    assign o_depth   = w_stk_count;

endmodule : int_return_unit
`default_nettype wire

// File: tb/tb_int_return_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_return_unit
//  Description : Self-checking bench for int_return_unit: directed scenarios
//                with literal expectations plus a randomized phase, all
//                cross-checked every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_return_unit;
    import int_return_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int PW    = 3;
    localparam int CW    = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           ie, int_req, rti;
    logic [AW-1:0]  int_vec, resume_pc;
    logic [PW-1:0]  int_pri;
    logic           int_ack, flush, rv, rti_err;
    logic [AW-1:0]  rpc;
    logic [PW-1:0]  cur_pri;
    logic [CW-1:0]  depth;

    int n_chk = 0;
    int n_err = 0;

    int_return_unit #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ie             (ie),
        .i_int_req        (int_req),
        .i_int_vec        (int_vec),
        .i_int_pri        (int_pri),
        .i_resume_pc      (resume_pc),
        .i_rti            (rti),
        .o_int_ack        (int_ack),
        .o_flush          (flush),
        .o_redirect_valid (rv),
        .o_redirect_pc    (rpc),
        .o_cur_pri        (cur_pri),
        .o_depth          (depth),
        .o_rti_err        (rti_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a LIFO of {pc, pri} and at most one pending
    // redirect. Evaluated on the falling edge with the inputs that the
    // next rising edge will see; checks outputs, then advances.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [PW-1:0] pri;
    } ent_t;

    ent_t          m_stk[$];
    ent_t          m_ent;
    bit            m_busy = 0;
    logic [AW-1:0] m_tgt  = '0;
    logic [PW-1:0] e_cur;
    int            e_depth;
    bit            e_ack, e_err;

    always @(negedge clk) begin
        if (rst) begin
            m_stk.delete();
            m_busy = 0;
            m_tgt  = '0;
        end else begin
            e_cur   = (m_stk.size() > 0) ? m_stk[$].pri : '0;
            e_depth = m_stk.size();
            chk("m_cur_pri", cur_pri, e_cur);
            chk("m_depth", depth, e_depth);
            if (m_busy) begin
                chk("m_flush", flush, 1);
                chk("m_redirect_valid", rv, 1);
                chk("m_redirect_pc", rpc, m_tgt);
                chk("m_int_ack", int_ack, 0);
                chk("m_rti_err", rti_err, 0);
                m_busy = 0;
            end else begin
                e_ack = int_req && ie && !rti && (int_pri > e_cur) && (e_depth < DEPTH);
                e_err = rti && (e_depth == 0);
                chk("m_flush", flush, 0);
                chk("m_redirect_valid", rv, 0);
                chk("m_int_ack", int_ack, e_ack);
                chk("m_rti_err", rti_err, e_err);
                if (rti && e_depth > 0) begin
                    m_ent  = m_stk.pop_back();
                    m_tgt  = m_ent.pc;
                    m_busy = 1;
                end else if (e_ack) begin
                    m_ent.pc  = resume_pc;
                    m_ent.pri = int_pri;
                    m_stk.push_back(m_ent);
                    m_tgt  = int_vec;
                    m_busy = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge,
    // literal checks happen 1 unit after that.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_int(input logic [AW-1:0] vec, input logic [PW-1:0] pri,
                          input logic [AW-1:0] pc);
        int_req = 1'b1; int_vec = vec; int_pri = pri; resume_pc = pc;
        #1 chk("int_ack_accept", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("redirect_vector", rpc, vec);
        cyc();
    endtask

    task automatic do_rti(input logic [AW-1:0] pc);
        rti = 1'b1;
        cyc();
        rti = 1'b0;
        #1 chk("rti_redirect_valid", rv, 1);
        chk("rti_redirect_epc", rpc, pc);
        cyc();
    endtask

    bit last_ack;

    initial begin
        rst = 1'b1; ie = 1'b0; int_req = 1'b0; rti = 1'b0;
        int_vec = '0; resume_pc = '0; int_pri = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_int_ack", int_ack, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_valid", rv, 0);
        chk("rst_redirect_pc", rpc, 0);
        chk("rst_cur_pri", cur_pri, 0);
        chk("rst_depth", depth, 0);
        chk("rst_rti_err", rti_err, 0);
        cyc();
        rst = 1'b0; ie = 1'b1;
        cyc();

        // Single interrupt and return
        int_req = 1'b1; int_vec = VEC_BUTTON; int_pri = 3'd2; resume_pc = 32'h24;
        #1 chk("t1_ack", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("t1_flush", flush, 1);
        chk("t1_rv", rv, 1);
        chk("t1_rpc", rpc, 32'h80);
        chk("t1_depth", depth, 1);
        chk("t1_cur_pri", cur_pri, 2);
        cyc();
        rti = 1'b1;
        #1 chk("t1_rti_err", rti_err, 0);
        chk("t1_rv_idle", rv, 0);
        cyc();
        rti = 1'b0;
        #1 chk("t1_ret_rv", rv, 1);
        chk("t1_ret_rpc", rpc, 32'h24);
        chk("t1_ret_depth", depth, 0);
        chk("t1_ret_cur_pri", cur_pri, 0);
        cyc();

        // Nesting and priority
        do_int(32'h200, 3'd1, 32'h10);
        int_req = 1'b1; int_vec = 32'h100; int_pri = 3'd2; resume_pc = 32'h90;
        #1 chk("t2_nest_ack", int_ack, 1);
        cyc();
        int_vec = 32'h400; resume_pc = 32'h300;   // held equal-priority request
        #1 chk("t2_enter_no_ack", int_ack, 0);
        chk("t2_depth2", depth, 2);
        chk("t2_rpc", rpc, 32'h100);
        repeat (3) begin
            cyc();
            #1 chk("t2_equal_pri_held", int_ack, 0);
        end
        cyc();
        rti = 1'b1;
        #1 chk("t2_rti_wins", int_ack, 0);
        cyc();
        rti = 1'b0;
        #1 chk("t2_ret_rpc", rpc, 32'h90);
        chk("t2_ret_cur_pri", cur_pri, 1);
        chk("t2_ret_no_ack", int_ack, 0);
        cyc();
        #1 chk("t2_held_acked", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("t2_held_vec", rpc, 32'h400);
        cyc();
        do_rti(32'h300);
        do_rti(32'h10);

        // Full stack
        for (int i = 0; i < DEPTH; i++) begin
            do_int(AW'(32'h2000 + 16*i), PW'(i + 1), AW'(32'h1000 + i));
        end
        int_req = 1'b1; int_pri = 3'd7; int_vec = 32'h3000; resume_pc = 32'h3004;
        repeat (5) begin
            #1 chk("t3_full_no_ack", int_ack, 0);
            chk("t3_full_depth", depth, 4);
            cyc();
        end
        int_req = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            do_rti(AW'(32'h1000 + i));
        end
        #1 chk("t3_empty_depth", depth, 0);

        // Empty RTI and RTI/request collision
        rti = 1'b1;
        #1 chk("t4_rti_err", rti_err, 1);
        cyc();
        rti = 1'b0;
        #1 chk("t4_err_one_cycle", rti_err, 0);
        chk("t4_no_redirect", rv, 0);
        chk("t4_depth0", depth, 0);
        cyc();
        do_int(32'h500, 3'd3, 32'h44);
        rti = 1'b1; int_req = 1'b1; int_pri = 3'd5; int_vec = 32'h600; resume_pc = 32'h48;
        #1 chk("t4_collide_no_ack", int_ack, 0);
        cyc();
        rti = 1'b0;
        #1 chk("t4_collide_ret_rpc", rpc, 32'h44);
        chk("t4_collide_ret_no_ack", int_ack, 0);
        cyc();
        #1 chk("t4_collide_then_ack", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("t4_collide_vec", rpc, 32'h600);
        cyc();
        do_rti(32'h48);

        // Masking
        ie = 1'b0; int_req = 1'b1; int_pri = 3'd1; int_vec = 32'h700; resume_pc = 32'h4c;
        repeat (10) begin
            #1 chk("t5_masked", int_ack, 0);
            cyc();
        end
        ie = 1'b1;
        #1 chk("t5_unmasked_ack", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("t5_vec", rpc, 32'h700);
        cyc();
        ie = 1'b0;
        do_rti(32'h4c);
        ie = 1'b1;

        // Reset in the ENTER cycle
        int_req = 1'b1; int_pri = 3'd3; int_vec = 32'h800; resume_pc = 32'h50;
        #1 chk("t6_ack", int_ack, 1);
        cyc();
        int_req = 1'b0;
        #1 chk("t6_enter_flush", flush, 1);
        rst = 1'b1;
        #1 chk("t6_rst_flush", flush, 0);
        chk("t6_rst_rv", rv, 0);
        chk("t6_rst_depth", depth, 0);
        chk("t6_rst_cur_pri", cur_pri, 0);
        cyc();
        rst = 1'b0;
        #1 chk("t6_idle_flush", flush, 0);
        chk("t6_idle_depth", depth, 0);
        cyc();
        do_int(32'h900, 3'd1, 32'h54);
        do_rti(32'h54);

        // Randomized phase, checked by the model
        last_ack = 0;
        for (int k = 0; k < 400; k++) begin
            if (!int_req || last_ack) begin
                int_req   = ($urandom_range(0, 1) == 1);
                int_pri   = PW'($urandom);
                int_vec   = $urandom;
                resume_pc = $urandom;
            end
            rti = ($urandom_range(0, 4) == 0);
            ie  = ($urandom_range(0, 7) != 0);
            #1 last_ack = int_ack;
            cyc();
        end
        int_req = 1'b0; rti = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule : tb_int_return_unit
`default_nettype wire
